// File: rtl/vga_pkg.sv
// Timing records, totals helpers and mode-FSM state type shared by the raster
// timing generator and its output pipeline.
package vga_pkg;

  localparam int TW = 12;

  typedef struct packed {
    logic [TW-1:0] h_disp;
    logic [TW-1:0] h_fp;
    logic [TW-1:0] h_sync;
    logic [TW-1:0] h_bp;
    logic [TW-1:0] v_disp;
    logic [TW-1:0] v_fp;
    logic [TW-1:0] v_sync;
    logic [TW-1:0] v_bp;
    logic          h_pol;   // 1 = sync pulse is active high
    logic          v_pol;
  } vga_timing_t;

  typedef enum logic {
    MS_RUN     = 1'b0,
    MS_PENDING = 1'b1
  } mode_state_t;

  function automatic logic [TW-1:0] h_total(input vga_timing_t t);
    return t.h_disp + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic logic [TW-1:0] v_total(input vga_timing_t t);
    return t.v_disp + t.v_fp + t.v_sync + t.v_bp;
  endfunction

  localparam vga_timing_t VGA_640x480 = '{
    h_disp: 12'd640, h_fp: 12'd16, h_sync: 12'd96,  h_bp: 12'd48,
    v_disp: 12'd480, v_fp: 12'd10, v_sync: 12'd2,   v_bp: 12'd33,
    h_pol:  1'b0,    v_pol: 1'b0
  };

  localparam vga_timing_t SVGA_800x600 = '{
    h_disp: 12'd800, h_fp: 12'd40, h_sync: 12'd128, h_bp: 12'd88,
    v_disp: 12'd600, v_fp: 12'd1,  v_sync: 12'd4,   v_bp: 12'd23,
    h_pol:  1'b1,    v_pol: 1'b1
  };

endpackage

// File: rtl/vga_out_pipe.sv
// Resettable register chain of configurable depth; every stage advances only
// on pix_en so the delay is counted in pixels rather than clocks.
module vga_out_pipe #(
  parameter int           W       = 8,
  parameter int           DEPTH   = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pix_en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else if (pix_en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Two-mode raster timing generator: pixel-enabled h/v counters, a mode FSM that
// swaps timing only at a frame boundary, and a delayed coherent output bundle.
//
//  state      | meaning
//  MS_RUN     | generating mode_q, no change requested
//  MS_PENDING | mode_sel differs from mode_q; switch at the next frame end
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int          CW       = 12,
  parameter vga_timing_t MODE0    = VGA_640x480,
  parameter vga_timing_t MODE1    = SVGA_800x600,
  parameter int          PIPE_DLY = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pix_en,
  input  logic          mode_sel,
  output logic          mode_active,
  output logic          mode_changed,
  output logic          video_on,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y
);

  localparam int            PW      = 7 + 2*CW;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [PW-1:0] RST_VEC = {1'b0, ~MODE0.h_pol, ~MODE0.v_pol, 4'b0000,
                                       {CW{1'b0}}, {CW{1'b0}}};

  logic [CW-1:0] h, v;
  logic          mode_q, chg_q, load;
  mode_state_t   state_q, state_d;
  vga_timing_t   cur;

  logic [CW-1:0] h_last, v_last, h_disp, v_disp, hs_beg, hs_end, vs_beg, vs_end;
  logic          h_wrap, frame_end;
  logic          dec_von, dec_hs, dec_vs, dec_ls, dec_fs, dec_mc;
  logic [PW-1:0] pipe_d, pipe_q;

  assign cur    = mode_q ? MODE1 : MODE0;
  assign h_last = CW'(h_total(cur)) - ONE;
  assign v_last = CW'(v_total(cur)) - ONE;
  assign h_disp = CW'(cur.h_disp);
  assign v_disp = CW'(cur.v_disp);
  assign hs_beg = CW'(cur.h_disp + cur.h_fp);
  assign hs_end = CW'(cur.h_disp + cur.h_fp + cur.h_sync);
  assign vs_beg = CW'(cur.v_disp + cur.v_fp);
  assign vs_end = CW'(cur.v_disp + cur.v_fp + cur.v_sync);

  assign h_wrap    = (h == h_last);
  assign frame_end = pix_en && h_wrap && (v == v_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        h <= '0;
        v <= (v == v_last) ? '0 : v + ONE;
      end else begin
        h <= h + ONE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      MS_RUN: begin
        if (mode_sel != mode_q) state_d = MS_PENDING;
      end
      MS_PENDING: begin
        if (mode_sel == mode_q) begin
          state_d = MS_RUN;
        end else if (frame_end) begin
          load    = 1'b1;
          state_d = MS_RUN;
        end
      end
      default: state_d = MS_RUN;
    endcase
  end

  // chg_q marks the first pixel of the frame that follows a mode load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MS_RUN;
      mode_q  <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        mode_q <= ~mode_q;
        chg_q  <= 1'b1;
      end else if (pix_en) begin
        chg_q  <= 1'b0;
      end
    end
  end

  assign dec_von = (h < h_disp) && (v < v_disp);
  assign dec_hs  = ((h >= hs_beg) && (h < hs_end)) ? cur.h_pol : ~cur.h_pol;
  assign dec_vs  = ((v >= vs_beg) && (v < vs_end)) ? cur.v_pol : ~cur.v_pol;
  assign dec_ls  = (h == '0);
  assign dec_fs  = dec_ls && (v == '0);
  assign dec_mc  = chg_q && dec_fs;

  assign pipe_d = {dec_von, dec_hs, dec_vs, dec_ls, dec_fs, dec_mc, mode_q, h, v};

  vga_out_pipe #(
    .W       (PW),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (RST_VEC)
  ) u_out_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .pix_en  (pix_en),
    .d       (pipe_d),
    .q       (pipe_q)
  );

  assign {video_on, hsync, vsync, line_start, frame_start,
          mode_changed, mode_active, x, y} = pipe_q;

endmodule
